// File: rtl/dense_accum.sv
// Multi-lane MAC accumulator with saturating accumulate and shifted, clipped emit.
// Optional ReLU at emit enabled by defining DENSE_ACCUM_RELU_EN.
module dense_accum #(
    parameter int DATA_W = 16,
    parameter int LANES  = 9,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic signed [ACC_W-1:0]      bias,
    input  logic [5:0]                   out_shift,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_W-1:0]      in_data,
    input  logic [LANES*DATA_W-1:0]      in_wgt,
    input  logic [$clog2(LANES+1)-1:0]   in_lanes,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_W-1:0]     out_data,
    output logic [CNT_W-1:0]             out_beats,
    output logic                         ovf
);

    localparam int LW    = $clog2(LANES+1);
    localparam int SUM_W = 2*DATA_W + LW;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX =
        {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN =
        {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t                     state, state_n;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           beat_cnt;
    logic                       accept, first;
    logic [LW-1:0]              lanes_eff;
    logic signed [2*DATA_W-1:0] d_x, w_x, prod;
    logic signed [SUM_W-1:0]    beat_sum;
    logic signed [EXT_W-1:0]    acc_ext;
    logic signed [ACC_W-1:0]    acc_sat, acc_shr;
    logic                       acc_clip, out_clip, ovf_acc;
    logic [CNT_W-1:0]           cnt_n;
    logic signed [DATA_W-1:0]   res;

    assign accept    = in_valid && in_ready;
    assign first     = (state == IDLE);
    assign lanes_eff = (in_lanes > LW'(LANES)) ? LW'(LANES) : in_lanes;

    always_comb begin
        beat_sum = '0;
        d_x      = '0;
        w_x      = '0;
        prod     = '0;
        for (int i = 0; i < LANES; i++) begin
            d_x  = (2*DATA_W)'($signed(in_data[i*DATA_W +: DATA_W]));
            w_x  = (2*DATA_W)'($signed(in_wgt[i*DATA_W +: DATA_W]));
            prod = d_x * w_x;
            if (LW'(i) < lanes_eff)
                beat_sum = beat_sum + SUM_W'(prod);
        end
    end

    // Widened add so the clip test sees the true sum before saturating.
    always_comb begin
        acc_ext  = (first ? EXT_W'(bias) : EXT_W'(acc)) + EXT_W'(beat_sum);
        acc_clip = 1'b0;
        if (acc_ext > ACC_MAX) begin
            acc_sat  = ACC_MAX[ACC_W-1:0];
            acc_clip = 1'b1;
        end else if (acc_ext < ACC_MIN) begin
            acc_sat  = ACC_MIN[ACC_W-1:0];
            acc_clip = 1'b1;
        end else begin
            acc_sat  = acc_ext[ACC_W-1:0];
        end
    end

    always_comb begin
        acc_shr  = acc_sat >>> out_shift;
        out_clip = 1'b0;
        if (acc_shr > OUT_MAX) begin
            res      = OUT_MAX[DATA_W-1:0];
            out_clip = 1'b1;
        end else if (acc_shr < OUT_MIN) begin
            res      = OUT_MIN[DATA_W-1:0];
            out_clip = 1'b1;
        end else begin
            res      = acc_shr[DATA_W-1:0];
        end
`ifdef DENSE_ACCUM_RELU_EN
        if (res[DATA_W-1])
            res = '0;
`endif
    end

    always_comb begin
        if (first)
            cnt_n = CNT_W'(1);
        else if (&beat_cnt)
            cnt_n = beat_cnt;
        else
            cnt_n = beat_cnt + 1'b1;
        ovf_acc = (first ? 1'b0 : ovf) | acc_clip;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_n = in_last ? EMIT : ACC;
                ACC:  if (accept && in_last) state_n = EMIT;
                EMIT: if (out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state != EMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            ovf       <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= (state_n == EMIT);
            if (accept) begin
                acc      <= acc_sat;
                beat_cnt <= cnt_n;
                ovf      <= ovf_acc | (in_last & out_clip);
                if (in_last) begin
                    out_data  <= res;
                    out_beats <= cnt_n;
                end
            end
        end
    end

endmodule

// File: doc/dense_accum.md
DENSE_ACCUM -- requirements
Module: dense_accum

Interface
REQ-001 Parameter DATA_W, default 16, signed width of each activation, weight and output.
REQ-002 Parameter LANES, default 9, activation/weight pairs presented per beat.
REQ-003 Parameter ACC_W, default 40, signed accumulator width; ACC_W >= 2*DATA_W+4.
REQ-004 Parameter CNT_W, default 16, beat-counter width.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, asynchronous, active-low reset.
REQ-007 Port clear, input, 1, synchronous abort of the current vector.
REQ-008 Port bias, input, ACC_W, signed accumulator seed, sampled on the first beat of a vector.
REQ-009 Port out_shift, input, 6, arithmetic right-shift applied to the accumulator at emit.
REQ-010 Port in_valid / in_ready, input / output, 1 / 1, beat handshake.
REQ-011 Port in_data / in_wgt, input / input, LANES*DATA_W each, lane i occupies bits [i*DATA_W +: DATA_W].
REQ-012 Port in_lanes, input, $clog2(LANES+1), count of valid lanes this beat; lanes >= in_lanes contribute 0.
REQ-013 Port in_last, input, 1, marks the final beat of a vector.
REQ-014 Port out_valid / out_ready, output / input, 1 / 1, result handshake.
REQ-015 Port out_data, output, DATA_W, signed saturated result.
REQ-016 Port out_beats, output, CNT_W, beats accumulated into out_data.
REQ-017 Port ovf, output, 1, sticky accumulator saturation flag for the current result.

Function
REQ-018 FSM states: IDLE, ACC, EMIT; in_ready = 1 in IDLE and ACC, 0 in EMIT.
REQ-019 Accept = in_valid && in_ready; a beat not accepted has no effect.
REQ-020 Beat sum = signed sum over lanes i < in_lanes of in_data[i]*in_wgt[i], at full precision.
REQ-021 Accept in IDLE: acc <= bias + beat sum; beat_cnt <= 1; ovf <= 0; next state is ACC, or EMIT if in_last.
REQ-022 Accept in ACC: acc <= acc + beat sum; beat_cnt <= beat_cnt + 1, saturating at all-ones; next state is EMIT if in_last.
REQ-023 Accumulator add saturates to the ACC_W signed limits and sets ovf on any clip; it never wraps.
REQ-024 Latency: in_last accepted at cycle N gives out_valid = 1 at N+1.
REQ-025 In EMIT, out_data = (acc >>> out_shift) clipped to the DATA_W signed range; clipping here also sets ovf.
REQ-026 out_data, out_beats and ovf hold stable while out_valid && !out_ready.
REQ-027 out_valid && out_ready moves the FSM to IDLE; out_valid drops the next cycle.
REQ-028 in_lanes = 0 is a legal beat: it adds 0 and increments beat_cnt.
REQ-029 in_lanes > LANES is treated as LANES.
REQ-030 clear, in any state, forces IDLE, acc = 0, beat_cnt = 0, out_valid = 0 and ovf = 0 the next cycle; any beat in the same cycle is discarded.
REQ-031 out_valid, out_data, out_beats and ovf are registered outputs; in_ready is decoded from the state only.

Reset
REQ-032 rst low asynchronously forces: state IDLE, acc 0, beat_cnt 0, out_valid 0, out_data 0, out_beats 0, ovf 0.
REQ-033 Reset mid-vector or mid-EMIT discards the partial result; the first accepted beat after release starts a new vector.

Configuration
REQ-034 Macro DENSE_ACCUM_RELU_EN defined: a negative clipped result is replaced by 0 at emit; ovf is unaffected.
REQ-035 Macro DENSE_ACCUM_RELU_EN undefined: signed result emitted unchanged; no ReLU logic exists.

Verification
REQ-036 LANES=9, bias=0, shift=0, one beat all data=2, all wgt=3, in_lanes=9, last -> out_data=54, out_beats=1, out_valid one cycle after accept.
REQ-037 Three beats, each lane product 1, in_lanes=9,9,4, bias=10 -> out_data=32, out_beats=3.
REQ-038 out_ready held low 5 cycles in EMIT while in_valid=1 -> in_ready=0, out_data stable, no beat consumed.
REQ-039 data=32767, wgt=32767, 9 lanes, shift=0 -> out_data=32767, ovf=1; shift=30 -> out_data=8, ovf=0.
REQ-040 bias=-100, one beat summing to 0, last -> out_data=-100 without the macro, 0 with DENSE_ACCUM_RELU_EN.
REQ-041 clear asserted mid-vector, then a new 1-beat vector summing to 7 -> out_data=7, out_beats=1; repeat the sequence with rst low instead of clear -> same result.
